multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control unit for the multicycle CPU datapath (PC, instruction memory, IR, register file, ALU, data memory).
- A five-state FSM (IF/ID/EXE/MEM/WB) sequences each instruction over 2–5 cycles according to its 6-bit opcode.
- Produces every datapath write enable and mux select.
- Sits beside the datapath inside the top-level CPU; the opcode comes from the IR and the zero flag from the ALU.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 3, ALU operation select width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous active-high reset
opcode  in  OP_W  IR[31:26]; stable from the cycle after IF
zero  in  1  ALU zero flag, valid in EXE
state  out  3  current FSM state (IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5)
pc_wre  out  1  PC load enable
ir_wre  out  1  IR load enable
reg_wre  out  1  register-file write enable
mem_rd  out  1  data memory read
mem_wr  out  1  data memory write
alu_src_b  out  1  0=rt register, 1=extended immediate
ext_sel  out  1  0=zero-extend, 1=sign-extend
alu_op  out  ALUOP_W  0=add 1=sub 2=and 3=or 4=slt
reg_dst  out  2  0=rt, 1=rd, 2=$31
wr_data_src  out  1  0=ALU result register, 1=memory data register
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs (jr)
halted  out  1  high while in HALT

Behaviour:
- State register updates on the rising edge of CLK.
- All other outputs are combinational from the state register and opcode.
- RST high at a clock edge: state <= IF. While RST is high, all of pc_wre, ir_wre, reg_wre, mem_rd, mem_wr are forced to 0; selects are 0.
- Reset mid-instruction aborts the instruction; no write enables are issued in that cycle.

Opcode classes:
- R-ALU 000000–000011: add, sub, and, or.
- I-ALU 000100–000111: addiu, andi, ori, slti.
- sw 100110; lw 100111.
- beq 110000; bne 110001.
- j 111000; jr 111001; jal 111010.
- halt 111111.
- Any other opcode is a NOP.

Sequences:
- R-ALU and I-ALU: IF->ID->EXE->WB->IF (4 cycles).
- lw: IF->ID->EXE->MEM->WB->IF (5 cycles).
- sw: IF->ID->EXE->MEM->IF (4 cycles).
- beq, bne: IF->ID->EXE->IF (3 cycles).
- j, jr, jal, NOP: IF->ID->IF (2 cycles).
- halt: IF->ID->HALT. HALT is held until RST.

Per-state outputs:
- IF: ir_wre=1.
- pc_wre=1 only in the final state of each instruction (WB for ALU/lw, MEM for sw, EXE for branches, ID for j/jr/jal/NOP). pc_wre=0 in HALT, so the PC freezes.
- pc_src in the final state:
  - 0 by default.
  - 1 for beq when zero=1, and for bne when zero=0.
  - 2 for j and jal.
  - 3 for jr.
- reg_wre=1 only in WB, plus ID for jal (reg_dst=2, writes PC+4).
- mem_rd=1 in MEM for lw; mem_wr=1 in MEM for sw.
- alu_src_b=1 for I-ALU, lw, sw.
- ext_sel=1 for addiu, slti, lw, sw, beq, bne; 0 for andi and ori.
- alu_op:
  - Functional ops map directly, e.g. add/addiu=0, sub=1, and/andi=2, or/ori=3, slti=4.
  - lw and sw use add (0); beq and bne use sub (1).
- reg_dst=1 for R-ALU and 0 for I-ALU/lw.
- wr_data_src=1 only for lw.
- Outputs are held valid for the whole state.
- Illegal state encodings (6, 7) return to IF on the next edge.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined, adds two output ports: cycle_cnt (32 bits) and instr_cnt (32 bits), both cleared by RST.
  - cycle_cnt increments every non-reset cycle except in HALT.
  - instr_cnt increments on every cycle with pc_wre=1.
  - Both counters wrap at 2^32-1 -> 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding enum;
  - opcode localparams;
  - ALU op codes;
  - reg_dst and pc_src encodings.
- The datapath shares this package.
- Sub-module ctrl_decode: purely combinational, (state, opcode, zero) -> control vector.
- The top-level multicycle_ctrl holds the state register, next-state logic and the optional counters.

Test Plan:
- RST=1 for 2 cycles, then 0 -> state=IF; ir_wre=1 in the first cycle after release; no write enables during reset.
- opcode=000000 (add) -> states 0,1,2,4,0. reg_wre=1 and pc_wre=1 only in WB, with reg_dst=1 and alu_op=0.
- opcode=100111 (lw) -> states 0,1,2,3,4. mem_rd=1 in MEM; wr_data_src=1 and reg_wre=1 in WB. opcode=100110 (sw) -> mem_wr=1 in MEM, then IF, with reg_wre never asserted.
- opcode=110000 (beq) with zero=1 -> pc_src=1 and pc_wre=1 in EXE. Same with zero=0 -> pc_src=0. opcode=110001 (bne) with zero=0 -> pc_src=1.
- opcode=111010 (jal) -> in ID: reg_wre=1, reg_dst=2, pc_src=2, pc_wre=1; next state IF.
- opcode=111111 (halt) -> state 5 held for 20 cycles with halted=1 and pc_wre=0; RST pulse -> IF. With MULTICYCLE_CTRL_PERF_EN: after add+lw+halt, instr_cnt=2 and cycle_cnt=11 on entering HALT.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding, opcodes, ALU codes and control-vector type for the multicycle CPU
package cpu_pkg;
    localparam int OP_W    = 6;
    localparam int ALUOP_W = 3;
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;
    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_AND   = 6'b000010;
    localparam logic [OP_W-1:0] OP_OR    = 6'b000011;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b000100;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b000101;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b000110;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b000111;
    localparam logic [OP_W-1:0] OP_SW    = 6'b100110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100111;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b110000;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b110001;
    localparam logic [OP_W-1:0] OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'd4;
    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;
    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_RS  = 2'd3;
    // CL_JMP covers j/jr/jal and every unassigned opcode: all finish in ID
    typedef enum logic [2:0] {
        CL_RALU, CL_IALU, CL_LW, CL_SW, CL_BR, CL_JMP, CL_HALT
    } op_class_t;
    typedef struct packed {
        logic               pc_wre;
        logic               ir_wre;
        logic               reg_wre;
        logic               mem_rd;
        logic               mem_wr;
        logic               alu_src_b;
        logic               ext_sel;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         reg_dst;
        logic               wr_data_src;
        logic [1:0]         pc_src;
    } ctrl_t;
    function automatic op_class_t op_class(input logic [OP_W-1:0] op);
        return op inside {[OP_ADD:OP_OR]} ? CL_RALU :
               op inside {[OP_ADDIU:OP_SLTI]} ? CL_IALU :
               op == OP_LW ? CL_LW :
               op == OP_SW ? CL_SW :
               (op == OP_BEQ || op == OP_BNE) ? CL_BR :
               op == OP_HALT ? CL_HALT : CL_JMP;
    endfunction
    function automatic logic [ALUOP_W-1:0] alu_of(input logic [OP_W-1:0] op);
        return (op == OP_SUB || op == OP_BEQ || op == OP_BNE) ? ALU_SUB :
               (op == OP_AND || op == OP_ANDI) ? ALU_AND :
               (op == OP_OR || op == OP_ORI) ? ALU_OR :
               op == OP_SLTI ? ALU_SLT : ALU_ADD;
    endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath bundle
//   opcode, zero           : datapath -> controller (IR[31:26], ALU zero flag)
//   state, halted          : controller status
//   pc_wre .. pc_src       : write enables and mux selects to the datapath
//   master = controller side, slave = datapath side
interface multicycle_ctrl_if;
    import cpu_pkg::*;
    logic [OP_W-1:0]    opcode;
    logic               zero;
    logic [2:0]         state;
    logic               pc_wre;
    logic               ir_wre;
    logic               reg_wre;
    logic               mem_rd;
    logic               mem_wr;
    logic               alu_src_b;
    logic               ext_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         reg_dst;
    logic               wr_data_src;
    logic [1:0]         pc_src;
    logic               halted;
    modport master (
        input  opcode, zero,
        output state, pc_wre, ir_wre, reg_wre, mem_rd, mem_wr, alu_src_b,
               ext_sel, alu_op, reg_dst, wr_data_src, pc_src, halted
    );
    modport slave (
        output opcode, zero,
        input  state, pc_wre, ir_wre, reg_wre, mem_rd, mem_wr, alu_src_b,
               ext_sel, alu_op, reg_dst, wr_data_src, pc_src, halted
    );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational (state, opcode, zero) -> datapath control vector
//   state  : current FSM state
//   opcode : IR opcode field
//   zero   : ALU zero flag (meaningful in EXE)
//   ctrl   : write enables and mux selects
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output ctrl_t           ctrl
);
    op_class_t cl;
    logic      act;
    logic      fin;
    logic      br;
    always_comb begin
        cl   = op_class(opcode);
        // opcode is not yet valid in IF, and HALT drives nothing
        act  = state inside {S_ID, S_EXE, S_MEM, S_WB};
        // last state of the instruction: the one that advances the PC
        fin  = (state == S_ID && cl == CL_JMP) || (state == S_EXE && cl == CL_BR) ||
               (state == S_MEM && cl == CL_SW) || state == S_WB;
        br   = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
        ctrl = '0;
        ctrl.ir_wre      = state == S_IF;
        ctrl.pc_wre      = fin;
        ctrl.reg_wre     = state == S_WB || (state == S_ID && opcode == OP_JAL);
        ctrl.mem_rd      = state == S_MEM && cl == CL_LW;
        ctrl.mem_wr      = state == S_MEM && cl == CL_SW;
        ctrl.alu_src_b   = act && cl inside {CL_IALU, CL_LW, CL_SW};
        ctrl.ext_sel     = act && opcode inside {OP_ADDIU, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
        ctrl.alu_op      = act ? alu_of(opcode) : ALU_ADD;
        ctrl.reg_dst     = !act ? RD_RT : cl == CL_RALU ? RD_RD : opcode == OP_JAL ? RD_RA : RD_RT;
        ctrl.wr_data_src = act && cl == CL_LW;
        ctrl.pc_src      = !fin ? PC_INC : br ? PC_BR :
                           (opcode == OP_J || opcode == OP_JAL) ? PC_JMP :
                           opcode == OP_JR ? PC_RS : PC_INC;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EXE/MEM/WB sequencer for the multicycle CPU datapath
//   CLK, RST  : clock, synchronous active-high reset
//   bus       : multicycle_ctrl_if.master (opcode/zero in, state/enables/selects out)
//   cycle_cnt, instr_cnt : performance counters, only with MULTICYCLE_CTRL_PERF_EN defined
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    multicycle_ctrl_if.master  bus
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instr_cnt
`endif
);
    state_t    state;
    state_t    next;
    op_class_t cl;
    ctrl_t     ctrl;
    ctrl_t     out;
    ctrl_decode u_decode (
        .state  (state),
        .opcode (bus.opcode),
        .zero   (bus.zero),
        .ctrl   (ctrl)
    );
    always_ff @(posedge CLK) begin
        state <= RST ? S_IF : next;
    end
    always_comb begin
        cl   = op_class(bus.opcode);
        next = S_IF;
        case (state)
            S_IF:   next = S_ID;
            S_ID:   next = cl == CL_HALT ? S_HALT : cl == CL_JMP ? S_IF : S_EXE;
            S_EXE:  next = (cl == CL_RALU || cl == CL_IALU) ? S_WB :
                           (cl == CL_LW || cl == CL_SW) ? S_MEM : S_IF;
            S_MEM:  next = cl == CL_LW ? S_WB : S_IF;
            S_HALT: next = S_HALT;
            default: next = S_IF;
        endcase
    end
    // reset cycle issues no enables, even mid-instruction
    assign out             = RST ? '0 : ctrl;
    assign bus.state       = state;
    assign bus.halted      = state == S_HALT;
    assign bus.pc_wre      = out.pc_wre;
    assign bus.ir_wre      = out.ir_wre;
    assign bus.reg_wre     = out.reg_wre;
    assign bus.mem_rd      = out.mem_rd;
    assign bus.mem_wr      = out.mem_wr;
    assign bus.alu_src_b   = out.alu_src_b;
    assign bus.ext_sel     = out.ext_sel;
    assign bus.alu_op      = out.alu_op;
    assign bus.reg_dst     = out.reg_dst;
    assign bus.wr_data_src = out.wr_data_src;
    assign bus.pc_src      = out.pc_src;
`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge CLK) begin
        cycle_cnt <= RST ? '0 : cycle_cnt + 32'(state != S_HALT);
        instr_cnt <= RST ? '0 : instr_cnt + 32'(out.pc_wre);
    end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized self-checking bench for multicycle_ctrl against a per-instruction sequence model
module tb_multicycle_ctrl;
    import cpu_pkg::*;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;
    multicycle_ctrl_if bus();
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ins = 32'd0;
`endif
    multicycle_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );
    int checks = 0;
    int errors = 0;
    int seq[6];
    int seq_n;
    bit perf_probe;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // state sequence of one instruction, straight from its opcode class
    task automatic set_seq(input logic [5:0] op);
        if (op < 6'd8) begin seq = '{0, 1, 2, 4, 0, 0}; seq_n = 4; end
        else if (op == OP_LW) begin seq = '{0, 1, 2, 3, 4, 0}; seq_n = 5; end
        else if (op == OP_SW) begin seq = '{0, 1, 2, 3, 0, 0}; seq_n = 4; end
        else if (op == OP_BEQ || op == OP_BNE) begin seq = '{0, 1, 2, 0, 0, 0}; seq_n = 3; end
        else begin seq = '{0, 1, 0, 0, 0, 0}; seq_n = 2; end
    endtask
    task automatic chk_perf();
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("instr_cnt", instr_cnt, m_ins);
`endif
    endtask
    task automatic clk_step(input bit r, input int st, input bit pc);
        @(posedge CLK);
        #1;
`ifdef MULTICYCLE_CTRL_PERF_EN
        m_cyc = r ? 32'd0 : m_cyc + 32'(st != 5);
        m_ins = r ? 32'd0 : m_ins + 32'(pc);
`else
        if (r && st < 0 && pc) $display("unreachable");
`endif
    endtask
    task automatic check_quiet(input string tag);
        chk({tag, " enables"}, 32'({bus.pc_wre, bus.ir_wre, bus.reg_wre, bus.mem_rd, bus.mem_wr}), 32'd0);
        chk({tag, " selects"}, 32'({bus.alu_src_b, bus.ext_sel, bus.alu_op, bus.reg_dst,
                                    bus.wr_data_src, bus.pc_src}), 32'd0);
    endtask
    task automatic check_cycle(input logic [5:0] op, input int st, input bit fin, input logic z);
        string p;
        bit ralu, ialu, lw, sw, beq, bne, jal;
        int alu, rd, pcs;
        p    = $sformatf("op%02h s%0d", op, st);
        ralu = op < 6'd4;
        ialu = op >= 6'd4 && op < 6'd8;
        lw   = op == OP_LW;
        sw   = op == OP_SW;
        beq  = op == OP_BEQ;
        bne  = op == OP_BNE;
        jal  = op == OP_JAL;
        chk({p, " state"}, 32'(bus.state), 32'(st));
        chk({p, " ir_wre"}, 32'(bus.ir_wre), 32'(st == 0));
        chk({p, " pc_wre"}, 32'(bus.pc_wre), 32'(fin));
        chk({p, " reg_wre"}, 32'(bus.reg_wre), 32'(st == 4 || (st == 1 && jal)));
        chk({p, " mem_rd"}, 32'(bus.mem_rd), 32'(st == 3 && lw));
        chk({p, " mem_wr"}, 32'(bus.mem_wr), 32'(st == 3 && sw));
        chk({p, " halted"}, 32'(bus.halted), 32'd0);
        if (st != 0) begin
            alu = ralu ? int'(op) : op == OP_ADDIU ? 0 : op == OP_ANDI ? 2 : op == OP_ORI ? 3 :
                  op == OP_SLTI ? 4 : (beq || bne) ? 1 : 0;
            rd  = ralu ? 1 : jal ? 2 : 0;
            pcs = !fin ? 0 : ((beq && z) || (bne && !z)) ? 1 : (op == OP_J || jal) ? 2 :
                  op == OP_JR ? 3 : 0;
            chk({p, " alu_src_b"}, 32'(bus.alu_src_b), 32'(ialu || lw || sw));
            chk({p, " ext_sel"}, 32'(bus.ext_sel), 32'(op == OP_ADDIU || op == OP_SLTI || lw || sw || beq || bne));
            chk({p, " alu_op"}, 32'(bus.alu_op), 32'(alu));
            chk({p, " reg_dst"}, 32'(bus.reg_dst), 32'(rd));
            chk({p, " wr_data_src"}, 32'(bus.wr_data_src), 32'(lw));
            chk({p, " pc_src"}, 32'(bus.pc_src), 32'(pcs));
        end
    endtask
    task automatic run_instr(input logic [5:0] op, input int zmode, input bit abort_ok);
        bit fin;
        logic z;
        set_seq(op);
        for (int k = 0; k < seq_n; k++) begin
            z = zmode < 0 ? 1'($urandom_range(0, 1)) : 1'(zmode);
            bus.opcode = op;
            bus.zero   = z;
            if (abort_ok && k > 0 && $urandom_range(0, 39) == 0) begin
                RST = 1'b1;
                @(negedge CLK);
                check_quiet("abort");
                chk_perf();
                clk_step(1'b1, 0, 1'b0);
                RST = 1'b0;
                return;
            end
            fin = k == seq_n - 1 && op != OP_HALT;
            @(negedge CLK);
            check_cycle(op, seq[k], fin, z);
            chk_perf();
            clk_step(1'b0, seq[k], fin);
        end
        if (op == OP_HALT) begin
            for (int i = 0; i < 20; i++) begin
                bus.zero = 1'($urandom_range(0, 1));
                @(negedge CLK);
                chk("halt state", 32'(bus.state), 32'd5);
                chk("halt halted", 32'(bus.halted), 32'd1);
                chk("halt enables", 32'({bus.pc_wre, bus.ir_wre, bus.reg_wre, bus.mem_rd, bus.mem_wr}), 32'd0);
                if (i == 0 && perf_probe) begin
`ifdef MULTICYCLE_CTRL_PERF_EN
                    chk("perf cycle@halt", cycle_cnt, 32'd11);
                    chk("perf instr@halt", instr_cnt, 32'd2);
`endif
                end
                chk_perf();
                clk_step(1'b0, 5, 1'b0);
            end
            RST = 1'b1;
            @(negedge CLK);
            check_quiet("halt rst");
            chk_perf();
            clk_step(1'b1, 5, 1'b0);
            RST = 1'b0;
        end
    endtask
    logic [5:0] ops[17] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, OP_SW, OP_LW,
                            OP_BEQ, OP_BNE, OP_J, OP_JR, OP_JAL, OP_HALT, 6'b101010};
    initial begin
        RST        = 1'b1;
        bus.opcode = 6'd0;
        bus.zero   = 1'b0;
        perf_probe = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check_quiet("reset");
            chk("reset state", 32'(bus.state), 32'd0);
            chk_perf();
            clk_step(1'b1, 0, 1'b0);
        end
        RST = 1'b0;
        perf_probe = 1'b1;
        run_instr(OP_ADD, -1, 1'b0);
        run_instr(OP_LW, -1, 1'b0);
        run_instr(OP_HALT, -1, 1'b0);
        perf_probe = 1'b0;
        run_instr(OP_SW, -1, 1'b0);
        run_instr(OP_BEQ, 1, 1'b0);
        run_instr(OP_BEQ, 0, 1'b0);
        run_instr(OP_BNE, 0, 1'b0);
        run_instr(OP_BNE, 1, 1'b0);
        run_instr(OP_JAL, -1, 1'b0);
        run_instr(OP_J, -1, 1'b0);
        run_instr(OP_JR, -1, 1'b0);
        run_instr(6'b001000, -1, 1'b0);
        for (int i = 0; i < 8; i++) run_instr(6'(i), -1, 1'b0);
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 19);
            run_instr(r < 17 ? ops[r] : 6'($urandom), -1, 1'b1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
